// File: rtl/mux_arb_pkg.sv
// Shared types for the 4-way round-robin output arbiter.
// Holds the requester count and the requester index type.
package mux_arb_pkg;
  localparam int N_REQ = 4;
  typedef logic [1:0] req_id_t;
endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick among 4 requesters.
// Scans from last+1 upward (mod 4); gnt is one-hot or zero.
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic [N_REQ-1:0] gnt,
  output logic             any,
  output logic [1:0]       id
);

  req_id_t idx;

  always_comb begin
    gnt = '0;
    any = 1'b0;
    id  = last;
    idx = last;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + req_id_t'(k);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/mux_4_1_rr_arb.sv
// Four requesters share one registered output beat.
// Round-robin grant; drain and refill in the same cycle.
module mux_4_1_rr_arb
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_id,
  input  logic             out_ready
);

  logic [N_REQ-1:0] gnt;
  logic             any;
  req_id_t          pick_id;
  req_id_t          last_grant;
  logic             free;
  logic             take;
  logic [WIDTH-1:0] mux_data;

  rr_pick_4 u_pick (
    .req  (in_valid),
    .last (last_grant),
    .gnt  (gnt),
    .any  (any),
    .id   (pick_id)
  );

  assign free = ~out_valid | out_ready;
  assign take = free & any;

  // Gated by rst so in_ready is quiet during reset.
  assign in_ready = gnt & {N_REQ{take & rst}};

  assign mux_data =
      ({WIDTH{gnt[0]}} & in_data0)
    | ({WIDTH{gnt[1]}} & in_data1)
    | ({WIDTH{gnt[2]}} & in_data2)
    | ({WIDTH{gnt[3]}} & in_data3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      last_grant <= 2'd3;
    end else if (free) begin
      out_valid <= any;
      if (any) begin
        out_data   <= mux_data;
        out_id     <= pick_id;
        last_grant <= pick_id;
      end
    end
  end

endmodule
